// File: rtl/alu_arbiter.sv
// Two-port round-robin arbiter in front of one shared multi-cycle ALU; result is tagged with requester id.
// Optional build macro ALU_FIXED_PRIO_EN: port 0 wins whenever both ports are valid.
module alu_arbiter #(
  parameter int WIDTH   = 32,
  parameter int MUL_LAT = 3,
  parameter int DIV_LAT = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [4:0]       req0_ctrl,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [4:0]       req1_ctrl,
  output logic             req1_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_y,
  output logic             out_id,
  output logic             out_err,
  output logic             busy
);

  localparam int MAXLAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int CW     = $clog2(MAXLAT) + 1;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t           state, state_n;
  logic             last_gnt;
  logic             gnt;
  logic             gnt_vld;
  logic             accept;
  logic [4:0]       sel_ctrl;
  logic [CW-1:0]    lat_sel;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_r, b_r;
  logic [4:0]       ctrl_r;
  logic             id_r;
  logic [WIDTH-1:0] alu_y;
  logic             alu_err;

  always_comb begin
    gnt_vld = req0_valid | req1_valid;
`ifdef ALU_FIXED_PRIO_EN
    gnt = ~req0_valid;
`else
    if (req0_valid && req1_valid) gnt = ~last_gnt;
    else                          gnt = ~req0_valid;
`endif
  end

  assign accept     = (state == IDLE) && gnt_vld;
  assign req0_ready = accept && !gnt;
  assign req1_ready = accept && gnt;
  assign busy       = (state != IDLE);
  assign sel_ctrl   = gnt ? req1_ctrl : req0_ctrl;

  always_comb begin
    lat_sel = '0;
    case (sel_ctrl)
      5'd3:    lat_sel = CW'(MUL_LAT - 1);
      5'd4:    lat_sel = CW'(DIV_LAT - 1);
      default: lat_sel = '0;
    endcase
  end

  // Evaluated from the latched operands so requester changes after accept are invisible.
  always_comb begin
    alu_y   = '0;
    alu_err = 1'b0;
    case (ctrl_r)
      5'd0: alu_y = a_r & b_r;
      5'd1: alu_y = a_r | b_r;
      5'd2: alu_y = ~a_r;
      5'd3: alu_y = a_r * b_r;
      5'd4: begin
        if (b_r == '0) begin
          alu_y   = '1;
          alu_err = 1'b1;
        end else begin
          alu_y = a_r / b_r;
        end
      end
      5'd5:    alu_y = a_r >> 3;
      5'd6:    alu_y = a_r << 2;
      default: alu_err = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (accept) state_n = BUSY;
      BUSY:    if (cnt == '0) state_n = RESP;
      RESP:    if (out_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_gnt  <= 1'b1;
      a_r       <= '0;
      b_r       <= '0;
      ctrl_r    <= '0;
      id_r      <= 1'b0;
      cnt       <= '0;
      out_valid <= 1'b0;
      out_y     <= '0;
      out_id    <= 1'b0;
      out_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            a_r      <= gnt ? req1_a : req0_a;
            b_r      <= gnt ? req1_b : req0_b;
            ctrl_r   <= sel_ctrl;
            id_r     <= gnt;
            last_gnt <= gnt;
            cnt      <= lat_sel;
          end
        end
        BUSY: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            out_y     <= alu_y;
            out_err   <= alu_err;
            out_id    <= id_r;
            out_valid <= 1'b1;
          end
        end
        RESP: if (out_ready) out_valid <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: expected results are queued on accept and compared when out_valid rises.
module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req1_valid;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic [4:0]  req0_ctrl, req1_ctrl;
  logic        req0_ready, req1_ready;
  logic        out_valid, out_ready;
  logic [31:0] out_y;
  logic        out_id, out_err, busy;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  typedef struct {
    logic [31:0] y;
    logic        id;
    logic        err;
    int          lat;
    int          acc;
  } exp_t;

  exp_t sb[$];

  alu_arbiter #(.WIDTH(32), .MUL_LAT(3), .DIV_LAT(8)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_ctrl(req0_ctrl), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_ctrl(req1_ctrl), .req1_ready(req1_ready),
    .out_valid(out_valid), .out_ready(out_ready), .out_y(out_y), .out_id(out_id), .out_err(out_err), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic exp_t model(input logic id, input logic [31:0] a, input logic [31:0] b,
                                 input logic [4:0] ctrl, input int acc);
    exp_t e;
    e.id = id; e.acc = acc; e.err = 1'b0; e.y = 32'h0; e.lat = 1;
    case (ctrl)
      5'd0: e.y = a & b;
      5'd1: e.y = a | b;
      5'd2: e.y = ~a;
      5'd3: begin e.y = 32'(64'(a) * 64'(b)); e.lat = 3; end
      5'd4: begin
        e.lat = 8;
        if (b == 0) begin e.y = 32'hFFFF_FFFF; e.err = 1'b1; end
        else e.y = a / b;
      end
      5'd5: e.y = a >> 3;
      5'd6: e.y = a << 2;
      default: e.err = 1'b1;
    endcase
    return e;
  endfunction

  task automatic apply_reset();
    rst = 1'b1;
    req0_valid = 0; req1_valid = 0; out_ready = 0;
    req0_a = 0; req0_b = 0; req0_ctrl = 0; req1_a = 0; req1_b = 0; req1_ctrl = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    sb.delete();
  endtask

  // Presents one request and holds it until accepted; pushes the expected result on the accept edge.
  task automatic issue(input logic port, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] ctrl, output bit ok);
    ok = 0;
    if (port) begin req1_a = a; req1_b = b; req1_ctrl = ctrl; req1_valid = 1; end
    else      begin req0_a = a; req0_b = b; req0_ctrl = ctrl; req0_valid = 1; end
    for (int i = 0; i < 50 && !ok; i++) begin
      #1;
      if (port ? req1_ready : req0_ready) begin
        @(posedge clk); #1;
        sb.push_back(model(port, a, b, ctrl, cyc));
        ok = 1;
      end else begin
        @(negedge clk);
      end
    end
    if (port) req1_valid = 0; else req0_valid = 0;
    @(negedge clk);
  endtask

  task automatic wait_out(output bit seen);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (out_valid) begin seen = 1; break; end
      @(negedge clk); #1;
    end
  endtask

  task automatic ack();
    out_ready = 1;
    @(negedge clk);
    out_ready = 0;
  endtask

  task automatic test_reset();
    apply_reset();
    rst = 1'b1;
    #1;
    checks++;
    if ({out_valid, out_y, out_id, out_err, busy} !== 36'h0) begin
      errors++;
      $display("FAIL reset_outputs got=%h exp=0", {out_valid, out_y, out_id, out_err, busy});
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_and();
    bit ok, seen;
    exp_t e;
    issue(1'b0, 32'hF0F0_F0F0, 32'hFF00_FF00, 5'd0, ok);
    wait_out(seen);
    checks++;
    if (!ok || !seen || sb.size() == 0) begin
      errors++; $display("FAIL and_handshake got=ok%0d/seen%0d exp=1/1", ok, seen);
    end else begin
      e = sb.pop_front();
      checks++;
      if ({out_y, out_id, out_err} !== {32'hF000_F000, 1'b0, 1'b0}) begin
        errors++; $display("FAIL and_result got=%h/%0d/%0d exp=f000f000/0/0", out_y, out_id, out_err);
      end
      checks++;
      if (cyc - e.acc != 1) begin
        errors++; $display("FAIL and_latency got=%0d exp=1", cyc - e.acc);
      end
    end
    ack();
  endtask

  task automatic test_round_robin();
    int got[$];
    int exp_order[4];
    int acc = 0;
    exp_t e;
`ifdef ALU_FIXED_PRIO_EN
    exp_order = '{0, 0, 0, 0};
`else
    exp_order = '{0, 1, 0, 1};
`endif
    apply_reset();
    req0_a = 32'h1; req0_b = 32'h2; req0_ctrl = 5'd1;
    req1_a = 32'h4; req1_b = 32'h8; req1_ctrl = 5'd1;
    req0_valid = 1; req1_valid = 1; out_ready = 1;
    for (int i = 0; i < 80 && (acc < 4 || sb.size() > 0); i++) begin
      #1;
      if (out_valid && sb.size() > 0) begin
        e = sb.pop_front();
        checks++;
        if ({out_y, out_id, out_err} !== {e.y, e.id, e.err}) begin
          errors++; $display("FAIL rr_result got=%h/%0d/%0d exp=%h/%0d/%0d", out_y, out_id, out_err, e.y, e.id, e.err);
        end
      end
      if (req0_ready && req1_ready) begin
        errors++; checks++; $display("FAIL rr_both_ready got=1/1 exp=one");
      end else if ((req0_ready || req1_ready) && acc < 4) begin
        got.push_back(req1_ready ? 1 : 0);
        sb.push_back(req1_ready ? model(1'b1, req1_a, req1_b, req1_ctrl, cyc + 1)
                                : model(1'b0, req0_a, req0_b, req0_ctrl, cyc + 1));
        acc++;
        if (acc == 4) begin @(posedge clk); #1; req0_valid = 0; req1_valid = 0; end
      end
      @(negedge clk);
    end
    out_ready = 0;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (k >= got.size() || got[k] != exp_order[k]) begin
        errors++; $display("FAIL rr_order[%0d] got=%0d exp=%0d", k, (k < got.size()) ? got[k] : -1, exp_order[k]);
      end
    end
  endtask

  task automatic test_mul();
    bit ok, seen;
    exp_t e;
    issue(1'b1, 32'h0001_0000, 32'h0003_0000, 5'd3, ok);
    wait_out(seen);
    checks++;
    if (!ok || !seen || sb.size() == 0) begin
      errors++; $display("FAIL mul_handshake got=ok%0d/seen%0d exp=1/1", ok, seen);
    end else begin
      e = sb.pop_front();
      checks++;
      if ({out_y, out_id, out_err} !== {32'h0, 1'b1, 1'b0}) begin
        errors++; $display("FAIL mul_result got=%h/%0d/%0d exp=0/1/0", out_y, out_id, out_err);
      end
      checks++;
      if (cyc - e.acc != 3) begin
        errors++; $display("FAIL mul_latency got=%0d exp=3", cyc - e.acc);
      end
    end
    ack();
  endtask

  task automatic test_div();
    logic [31:0] ta[3] = '{32'd100, 32'd5, 32'd7};
    logic [31:0] tbv[3] = '{32'd7, 32'd0, 32'd3};
    logic [4:0]  tc[3] = '{5'd4, 5'd4, 5'd9};
    bit ok, seen;
    exp_t e;
    for (int k = 0; k < 3; k++) begin
      issue(1'b0, ta[k], tbv[k], tc[k], ok);
      wait_out(seen);
      checks++;
      if (!ok || !seen || sb.size() == 0) begin
        errors++; $display("FAIL div_handshake[%0d] got=ok%0d/seen%0d exp=1/1", k, ok, seen);
      end else begin
        e = sb.pop_front();
        checks++;
        if ({out_y, out_id, out_err} !== {e.y, e.id, e.err}) begin
          errors++; $display("FAIL div_result[%0d] got=%h/%0d exp=%h/%0d", k, out_y, out_err, e.y, e.err);
        end
        checks++;
        if (cyc - e.acc != e.lat) begin
          errors++; $display("FAIL div_latency[%0d] got=%0d exp=%0d", k, cyc - e.acc, e.lat);
        end
      end
      ack();
    end
  endtask

  task automatic test_backpressure();
    bit ok, seen;
    exp_t e;
    issue(1'b0, 32'h4000_0001, 32'h0, 5'd6, ok);
    wait_out(seen);
    checks++;
    if (!ok || !seen || sb.size() == 0) begin
      errors++; $display("FAIL bp_handshake got=ok%0d/seen%0d exp=1/1", ok, seen);
      ack();
      return;
    end
    e = sb.pop_front();
    req0_valid = 1; req1_valid = 1; req0_ctrl = 5'd0; req1_ctrl = 5'd1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      checks++;
      if ({out_valid, out_y, out_id, out_err, req0_ready, req1_ready, busy} !==
          {1'b1, e.y, e.id, e.err, 1'b0, 1'b0, 1'b1}) begin
        errors++;
        $display("FAIL bp_hold[%0d] got=%h exp=%h", i, {out_valid, out_y, out_id, out_err, req0_ready, req1_ready, busy},
                 {1'b1, e.y, e.id, e.err, 1'b0, 1'b0, 1'b1});
      end
    end
    req0_valid = 0; req1_valid = 0;
    out_ready = 1;
    @(posedge clk); #1;
    out_ready = 0;
    checks++;
    if ({out_valid, busy} !== 2'b00) begin
      errors++; $display("FAIL bp_release got=%b exp=00", {out_valid, busy});
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    bit ok, seen, stale;
    exp_t e;
    issue(1'b1, 32'd1000, 32'd3, 5'd4, ok);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if ({out_valid, out_y, out_id, out_err, busy} !== 36'h0) begin
      errors++; $display("FAIL midreset_outputs got=%h exp=0", {out_valid, out_y, out_id, out_err, busy});
    end
    @(negedge clk);
    rst = 1'b0;
    sb.delete();
    stale = 0;
    out_ready = 1;
    repeat (12) begin @(negedge clk); if (out_valid) stale = 1; end
    out_ready = 0;
    checks++;
    if (stale) begin errors++; $display("FAIL midreset_stale got=out_valid exp=none"); end
    req1_a = 32'd5; req1_b = 32'd6; req1_ctrl = 5'd0; req1_valid = 1;
    req0_a = 32'h0000_00FF; req0_b = 32'h0000_0F0F; req0_ctrl = 5'd0; req0_valid = 1;
    #1;
    checks++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      errors++; $display("FAIL midreset_first_grant got=%b exp=10", {req0_ready, req1_ready});
    end
    issue(1'b0, 32'h0000_00FF, 32'h0000_0F0F, 5'd0, ok);
    req1_valid = 0;
    wait_out(seen);
    checks++;
    if (!ok || !seen || sb.size() == 0) begin
      errors++; $display("FAIL midreset_handshake got=ok%0d/seen%0d exp=1/1", ok, seen);
    end else begin
      e = sb.pop_front();
      checks++;
      if ({out_y, out_id, out_err} !== {32'h0000_000F, 1'b0, 1'b0}) begin
        errors++; $display("FAIL midreset_result got=%h/%0d/%0d exp=0000000f/0/0", out_y, out_id, out_err);
      end
    end
    ack();
  endtask

  initial begin
    test_reset();
    test_and();
    test_round_robin();
    test_mul();
    test_div();
    test_backpressure();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
